// File: rtl/ram_scan_reader.sv
// Paced read-address scanner for the scratch RAM: advances on a tick or a manual step,
// waits out the RAM read latency, then latches address and word for the display stage.
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int TICK_CNT = 25_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              wrap
);

    localparam int                CNT_W    = $clog2(TICK_CNT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CNT - 1);
    // lat holds the remaining WAIT cycles minus one, so WAIT lasts exactly RD_LAT cycles
    localparam logic [1:0]        LAT_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_lat;
    logic                r_pend;
    logic                r_step_d;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;
    logic                r_busy;
    logic                r_wrap;

    logic                w_tick;
    logic                w_step_edge;
    logic                w_ae;
    logic                w_re;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_tick      = enable && (r_tick_cnt == CNT_LAST);
    assign w_step_edge = step && !r_step_d;
    assign w_ae        = enable ? w_tick : w_step_edge;
    assign w_re        = wr_en && (wr_addr == r_rd_addr);
    assign w_addr_inc  = r_rd_addr + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_step_d   <= 1'b0;
        end else begin
            r_step_d <= step;
            if (!enable || (r_tick_cnt == CNT_LAST)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_WAIT;
            r_lat        <= LAT_LOAD;
            r_pend       <= 1'b0;
            r_rd_addr    <= '0;
            r_disp_addr  <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    if (w_ae) begin
                        r_rd_addr <= w_addr_inc;
                        r_wrap    <= &r_rd_addr;
                        r_lat     <= LAT_LOAD;
                        r_state   <= S_WAIT;
                        r_busy    <= 1'b1;
                    end else if (w_re) begin
                        r_lat   <= LAT_LOAD;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_tick) begin
                        r_pend <= 1'b1;
                    end
                    // A write hitting the in-flight address restarts the latency window
                    if (w_re) begin
                        r_lat <= LAT_LOAD;
                    end else if (r_lat == 2'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                S_CAPTURE: begin
                    r_disp_addr  <= r_rd_addr;
                    r_disp_data  <= rd_data;
                    r_disp_valid <= 1'b1;
                    if (r_pend || w_ae) begin
                        r_pend    <= 1'b0;
                        r_rd_addr <= w_addr_inc;
                        r_wrap    <= &r_rd_addr;
                        r_lat     <= LAT_LOAD;
                        r_state   <= S_WAIT;
                    end else if (w_re) begin
                        r_lat   <= LAT_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HOLD;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr    = r_rd_addr;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign busy       = r_busy;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: the driver queues expected captures and wrap
// pulses with their cycle numbers; a negedge monitor pops and compares on every change.
module tb_ram_scan_reader;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 3;
    localparam int TICK_CNT = 4;
    localparam int RD_LAT   = 1;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              enable   = 1'b0;
    logic              step     = 1'b0;
    logic              wr_en    = 1'b0;
    logic [ADDR_W-1:0] wr_addr  = '0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              ram_load = 1'b1;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              busy;
    logic              wrap;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] shadow [32];

    typedef struct packed {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cap_t;

    cap_t        sb_q[$];
    int          wrap_q[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  prev   = '0;
    logic [ADDR_W-1:0] exp_addr;

    ram_scan_reader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TICK_CNT(TICK_CNT),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .step      (step),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered q, read-before-write on a same-address collision
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= 3'(i);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    always @(negedge clk) begin
        logic [8:0] cur;
        cap_t       e;
        int         w;
        cur = {disp_valid, disp_addr, disp_data};
        if (reset) begin
            prev = cur;
        end else begin
            if (wrap) begin
                checks++;
                if (wrap_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_unexpected actual cyc=%0d required no pulse", cyc);
                end else begin
                    w = wrap_q.pop_front();
                    if (w != cyc) begin
                        errors++;
                        $display("FAIL wrap_cycle actual cyc=%0d required cyc=%0d", cyc, w);
                    end else begin
                        $display("wrap  cyc=%0d ok", cyc);
                    end
                end
            end
            if (cur != prev) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL capture_unexpected actual cyc=%0d addr=%0d data=%0d valid=%0b required no change",
                             cyc, disp_addr, disp_data, disp_valid);
                end else begin
                    e = sb_q.pop_front();
                    if (e.cyc != cyc || e.addr != disp_addr || e.data != disp_data || !disp_valid) begin
                        errors++;
                        $display("FAIL capture actual cyc=%0d addr=%0d data=%0d valid=%0b required cyc=%0d addr=%0d data=%0d valid=1",
                                 cyc, disp_addr, disp_data, disp_valid, e.cyc, e.addr, e.data);
                    end else begin
                        $display("capture cyc=%0d addr=%0d data=%0d ok", cyc, disp_addr, disp_data);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic push_cap(input logic [ADDR_W-1:0] a, input int lead);
        cap_t e;
        e.cyc  = cyc + lead;
        e.addr = a;
        e.data = shadow[a];
        sb_q.push_back(e);
    endtask

    task automatic step_pulse();
        step     = 1'b1;
        exp_addr = exp_addr + 5'd1;
        push_cap(exp_addr, 3);
        nclk(1);
        step = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"},    int'(rd_addr),    0);
        chk({tag, "_disp_addr"},  int'(disp_addr),  0);
        chk({tag, "_disp_data"},  int'(disp_data),  0);
        chk({tag, "_disp_valid"}, int'(disp_valid), 0);
        chk({tag, "_busy"},       int'(busy),       1);
        chk({tag, "_wrap"},       int'(wrap),       0);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 32; i++) shadow[i] = 3'(i);
        exp_addr = '0;

        // Reset release, automatic read of address 0
        nclk(3);
        chk_reset_outputs("rst");
        ram_load = 1'b0;
        reset    = 1'b0;
        push_cap(5'd0, 2);
        chk("busy_after_release", int'(busy), 1);
        nclk(8);
        chk("hold_busy", int'(busy), 0);
        chk("sb_drain_reset", sb_q.size(), 0);

        // Manual steps, then step held high gives a single advance
        repeat (3) begin
            step_pulse();
            nclk(10);
        end
        step     = 1'b1;
        exp_addr = exp_addr + 5'd1;
        push_cap(exp_addr, 3);
        nclk(20);
        step = 1'b0;
        nclk(5);
        step_pulse();
        nclk(6);
        chk("rd_addr_at_5", int'(rd_addr), 5);

        // Write to the displayed address forces a re-read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 3'd7; shadow[5] = 3'd7;
        push_cap(5'd5, 3);
        nclk(1);
        wr_en = 1'b0;
        chk("re_busy", int'(busy), 1);
        nclk(6);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 3'd7; shadow[6] = 3'd7;
        nclk(1);
        wr_en = 1'b0;
        chk("other_addr_busy", int'(busy), 0);
        nclk(6);
        chk("other_addr_busy_late", int'(busy), 0);

        // Step edge with a simultaneous write to the next address
        step = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 3'd6; shadow[6] = 3'd6;
        exp_addr = exp_addr + 5'd1;
        push_cap(exp_addr, 3);
        nclk(1);
        step = 1'b0; wr_en = 1'b0;
        nclk(6);

        // Auto scan for 140 cycles, including one wrap and an ignored step edge
        base   = cyc;
        enable = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (exp_addr == 5'd31) wrap_q.push_back(base + 4 * k);
            exp_addr = exp_addr + 5'd1;
            push_cap(exp_addr, 4 * k + 2);
        end
        nclk(10);
        step = 1'b1;
        nclk(1);
        step = 1'b0;
        nclk(129);
        enable = 1'b0;
        nclk(6);
        chk("rd_addr_after_auto", int'(rd_addr), 9);

        // Reset while a read is in flight
        step = 1'b1;
        nclk(1);
        step = 1'b0;
        chk("wait_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("rst2");
        exp_addr = '0;
        nclk(2);
        reset = 1'b0;
        push_cap(5'd0, 2);
        nclk(8);
        chk("rst2_hold_busy", int'(busy), 0);
        chk("rst2_rd_addr", int'(rd_addr), 0);

        chk("sb_empty", sb_q.size(), 0);
        chk("wrap_q_empty", wrap_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
